output_write_buffer: RTL
========================

OUTPUT_WRITE_BUFFER -- requirements
Module: output_write_buffer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): DATA_WIDTH, 16, element width; MEM_BW, 8, elements per beat; ADDR_WIDTH, 16, element-address width; FIFO_DEPTH, 4, buffered beats (power of 2); TILE_BEATS, 32, beats per tile (4 rows x 64 cols / 8).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  the single clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  begin one tile write; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  tile base element address; latched on accepted start.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  beat accepted when in_valid and in_ready are both high.
- in_data  in  MEM_BW*DATA_WIDTH  beat payload; lane k in bits [k*DATA_WIDTH +: DATA_WIDTH].
- mem_req  out  1  memory write request.
- mem_gnt  in  1  write completes when mem_req and mem_gnt are both high.
- mem_addr  out  ADDR_WIDTH  element address of the current write.
- mem_wdata  out  MEM_BW*DATA_WIDTH  write payload.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse after the last write of a tile.

Function
REQ-003 The FSM SHALL have states IDLE, RUN, DRAIN and DONE; reset enters IDLE.
REQ-004 In IDLE, start=1 SHALL latch base_addr, clear the accept count and issue count, and enter RUN on the next cycle.
REQ-005 start SHALL be ignored in RUN, DRAIN and DONE.
REQ-006 in_ready SHALL be combinational: (state==RUN) and FIFO not full and accept count < TILE_BEATS.
REQ-007 in_ready SHALL use the registered full flag, so no push occurs when the FIFO is full, even in a cycle that pops.
REQ-008 An accepted beat SHALL be pushed into the FIFO, and the accept count SHALL increment.
REQ-009 The cycle that accepts beat TILE_BEATS SHALL move RUN to DRAIN.
REQ-010 mem_req SHALL be high whenever state is RUN or DRAIN and the FIFO is not empty.
REQ-011 mem_wdata SHALL equal the FIFO head.
REQ-012 mem_addr SHALL equal base + issue count * MEM_BW, computed modulo 2^ADDR_WIDTH (wrap, no error).
REQ-013 While mem_req=1 and mem_gnt=0, mem_req, mem_addr and mem_wdata SHALL hold stable.
REQ-014 On mem_req and mem_gnt both high, the FIFO SHALL pop and the issue count SHALL increment.
REQ-015 A push and a pop in the same cycle SHALL leave occupancy unchanged and preserve order.
REQ-016 A beat pushed into an empty FIFO SHALL appear on mem_req/mem_wdata the following cycle (one-cycle latency).
REQ-017 When the issue count reaches TILE_BEATS in DRAIN, the FSM SHALL enter DONE. If beat TILE_BEATS is both accepted and the FIFO drains in RUN, DRAIN SHALL still be visited for one cycle.
REQ-018 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-019 The accept count and issue count SHALL each be $clog2(TILE_BEATS)+1 bits wide.
REQ-020 No beat SHALL ever be dropped or duplicated: issue count <= accept count at all times.

Reset
REQ-021 When rst_n=0, at any time including mid-tile, the block SHALL go to IDLE, empty the FIFO, and zero the counters and latched base.
REQ-022 During reset, in_ready, mem_req, busy and done SHALL all be 0, and mem_addr and mem_wdata SHALL be 0.
REQ-023 After rst_n deasserts, the block SHALL wait for a fresh start.

Verification
REQ-024 Basic tile: start with base_addr=0x0100; in_valid held high; mem_gnt held high -> 32 writes at addresses 0x0100, 0x0108, ..., 0x01F8 with matching data; a single done pulse; busy low afterwards.
REQ-025 Backpressure: mem_gnt=0 for 10 cycles after start -> exactly 4 beats are accepted, then in_ready=0; mem_req, mem_addr and mem_wdata stay stable. Raising mem_gnt resumes in order with no loss.
REQ-026 Address wrap: base_addr=0xFFF8 -> the second write goes to address 0x0000 and the last write to 0x00F0.
REQ-027 Start ignored: pulse start with base_addr=0x2000 in RUN of a tile started at 0x0000 -> addresses are unaffected, and exactly one done is produced.
REQ-028 Mid-tile reset: assert rst_n=0 after 10 accepted beats -> mem_req=0 and in_ready=0 immediately. After release, a new tile at 0x0300 completes all 32 fresh beats.
REQ-029 Random stall: random in_valid and mem_gnt at 50% -> scoreboard shows in-order data, 32 writes, one done.

Source files
------------

// File: rtl/output_write_buffer_if.sv
// Tile write-buffer bundle: upstream beat handshake, tile control/status, memory write port.
// master drives beats, start and grants; slave is the buffer.
interface output_write_buffer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_BW     = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                         start;
  logic [ADDR_WIDTH-1:0]        base_addr;
  logic                         in_valid;
  logic                         in_ready;
  logic [MEM_BW*DATA_WIDTH-1:0] in_data;
  logic                         mem_req;
  logic                         mem_gnt;
  logic [ADDR_WIDTH-1:0]        mem_addr;
  logic [MEM_BW*DATA_WIDTH-1:0] mem_wdata;
  logic                         busy;
  logic                         done;

  modport master (
    output start, base_addr, in_valid, in_data, mem_gnt,
    input  in_ready, mem_req, mem_addr, mem_wdata, busy, done
  );

  modport slave (
    input  start, base_addr, in_valid, in_data, mem_gnt,
    output in_ready, mem_req, mem_addr, mem_wdata, busy, done
  );
endinterface

// File: rtl/output_write_buffer.sv
// Buffers one tile of TILE_BEATS beats through a FIFO_DEPTH FIFO into sequential memory writes; push-to-req latency 1 cycle.
// Backpressure: in_ready drops on registered FIFO-full or tile complete; mem_req/addr/wdata hold until mem_gnt.
module output_write_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_BW     = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TILE_BEATS = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output_write_buffer_if.slave   bus
);
  localparam int BEAT_W = MEM_BW * DATA_WIDTH;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int CNT_W  = $clog2(TILE_BEATS) + 1;

  localparam logic [OCC_W-1:0]      DEPTH_OCC = OCC_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]      TILE_CNT  = CNT_W'(TILE_BEATS);
  localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(TILE_BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(MEM_BW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [CNT_W-1:0]      acc_cnt;
  logic [CNT_W-1:0]      iss_cnt;

  logic [BEAT_W-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [OCC_W-1:0]      occ;
  logic [OCC_W-1:0]      occ_nxt;
  logic                  full_q;
  logic                  empty_q;

  logic                  active;
  logic                  push;
  logic                  pop;
  logic                  start_acc;

  // Handshake qualifiers; in_ready looks only at registered flags so a pop never frees a slot early.
  assign active    = (state_q == RUN) || (state_q == DRAIN);
  assign start_acc = (state_q == IDLE) && bus.start;

  assign bus.in_ready  = (state_q == RUN) && !full_q && (acc_cnt < TILE_CNT);
  assign bus.mem_req   = active && !empty_q;
  assign bus.mem_wdata = fifo_mem[rd_ptr];
  assign bus.mem_addr  = base_q + (ADDR_WIDTH'(iss_cnt) * STRIDE);
  assign bus.busy      = active;
  assign bus.done      = (state_q == DONE);

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.mem_req && bus.mem_gnt;

  always_comb begin
    occ_nxt = occ;
    if (push && !pop) begin
      occ_nxt = occ + 1'b1;
    end else if (pop && !push) begin
      occ_nxt = occ - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= bus.in_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      occ     <= occ_nxt;
      full_q  <= (occ_nxt == DEPTH_OCC);
      empty_q <= (occ_nxt == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q  <= '0;
      acc_cnt <= '0;
      iss_cnt <= '0;
    end else if (start_acc) begin
      base_q  <= bus.base_addr;
      acc_cnt <= '0;
      iss_cnt <= '0;
    end else begin
      if (push) begin
        acc_cnt <= acc_cnt + 1'b1;
      end
      if (pop) begin
        iss_cnt <= iss_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // DRAIN exits on the registered issue count, so it is always occupied for at least one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (push && (acc_cnt == LAST_CNT)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (iss_cnt == TILE_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  a_no_overissue: assert property (@(posedge clk) disable iff (!rst_n)
    iss_cnt <= acc_cnt);

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.mem_req && !bus.mem_gnt) |=>
      (bus.mem_req && $stable(bus.mem_addr) && $stable(bus.mem_wdata)));

  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    bus.done |=> !bus.done);

endmodule
